// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder is sequenced LSB first, one bit per clock.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output 'ovf'.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry_out, sum_bit} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  state_t           state_r;
  state_t           next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] res_r;
  logic [1:0]       fa_s;
  logic [WIDTH-1:0] res_nx_s;
  logic             last_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic and the combinational bit slice
  always_comb begin
    next_s   = state_r;
    fa_s     = full_add(a_r[0], b_r[0], c_r);
    last_s   = (cnt_r == LAST_BIT);
    res_nx_s = WIDTH'({fa_s[0], res_r} >> 1);
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s = RUN;
        end else begin
          next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_s = DONE;
        end else begin
          next_s = RUN;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Operand shift registers, carry, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      cnt_r <= '0;
      res_r <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= cin;
            cnt_r <= '0;
            res_r <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          c_r   <= fa_s[1];
          res_r <= res_nx_s;
          // Counter wraps to zero on the final bit rather than overflowing.
          if (last_s) begin
            cnt_r <= '0;
            sum   <= res_nx_s;
            carry <= fa_s[1];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= c_r ^ fa_s[1];
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered status outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_s != IDLE);
      done <= (next_s == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, carry8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, carry4, ovf4;
  logic [3:0] a4, b4, sum4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    int         cyc;
  } exp8_t;

  typedef struct {
    logic [4:0] res;
    logic       ovf;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance: every done pulse must match the queue head.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.sum));
        chk("carry8", 32'(carry8), 32'(e.carry));
        chk("latency8", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done4: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        chk("sum4", 32'({carry4, sum4}), 32'(e.res));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
      end
    end
  end

  // Drives a one-cycle start pulse and queues the hand-computed result.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back('{es, ec, eo, cyc + 9});
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  task automatic wait_drain8();
    int n;
    n = 0;
    while ((q8.size() != 0 || busy8) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain8_timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int n;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_carry", 32'(carry8), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic add with busy-duration measurement
    issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 32'd9);
    wait_drain8();

    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_drain8();
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_drain8();

    // start re-pulsed during RUN must be ignored
    issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    wait_drain8();
    repeat (12) @(posedge clk);
    chk("repulse_extra", q8.size(), 32'd0);

    // start held high: one result every WIDTH+2 cycles
    @(posedge clk); #1;
    a8 = 8'h25; b8 = 8'h17; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back('{8'h3D, 1'b0, 1'b0, cyc + 9});
    q8.push_back('{8'h3D, 1'b0, 1'b0, cyc + 19});
    q8.push_back('{8'h3D, 1'b0, 1'b0, cyc + 29});
    repeat (25) @(posedge clk);
    #1 start8 = 1'b0;
    wait_drain8();
    repeat (3) @(posedge clk);
    chk("held_sum", 32'(sum8), 32'h3D);

    // Reset during RUN aborts the operation
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_carry", 32'(carry8), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    issue8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
    wait_drain8();

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] r;
          logic [3:0] xa, xb;
          xa = 4'(ia); xb = 4'(ib);
          r = 5'(ia + ib + ic);
          @(posedge clk); #1;
          a4 = xa; b4 = xb; cin4 = ic[0]; start4 = 1'b1;
          q4.push_back('{r, (xa[3] == xb[3]) && (r[3] != xa[3])});
          @(posedge clk); #1 start4 = 1'b0;
          repeat (4) @(posedge clk);
        end
      end
    end
    n = 0;
    while ((q4.size() != 0 || busy4) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain4_timeout", 32'(n >= 100), 32'd0);
    chk("q8_empty", q8.size(), 32'd0);
    chk("q4_empty", q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
